cic_interpolator: RTL and testbench
===================================

Name: cic_interpolator

Overview:
- N-stage CIC interpolator, the transmit-side counterpart of the CIC decimator in the DFE chain.
- Accepts s16.15 samples at the low rate through a valid/ready handshake.
- Runs N comb stages at input rate, then zero-stuffs by L = 2^Interpolation_Factor, then runs N integrators at output rate.
- Emits normalized s16.15 samples with out_valid, one per output tick.

Parameters:
- DATA_WIDTH, 16: input/output sample width, s16.15.
- N_STAGES, 4: number of comb stages and number of integrator stages (differential delay M = 1).
- MAX_LOG2_L, 4: largest supported log2 interpolation factor (L ≤ 16).
- ACC_WIDTH, 28: internal width, DATA_WIDTH + N_STAGES*MAX_LOG2_L − MAX_LOG2_L.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- EN  in  1  block enable; when low, all state holds.
- bypass  in  1  pass-through mode.
- x_n  in  DATA_WIDTH  signed input sample, s16.15.
- in_valid  in  1  x_n is valid.
- in_ready  out  1  block can accept a sample this cycle.
- Interpolation_Factor  in  3  k, with L = 2^k; values 5–7 are clamped to 4.
- y_n  out  DATA_WIDTH  signed output sample, s16.15.
- out_valid  out  1  y_n is a new output sample.

Behaviour:
- Reset (rst = 1 at a clk edge), effective at any time including mid-stream:
  - y_n = 0, out_valid = 0.
  - Phase counter p = 0; comb delays, integrators and zero-stuff register u all cleared.
  - Registered factor k_r is loaded with the clamped Interpolation_Factor.
- Handshake:
  - in_ready = EN && !rst && (bypass || p == 0).
  - accept = in_valid && in_ready.
  - When in_valid is low at p == 0, the block stalls: no step, out_valid = 0.
- Step: step = EN && !bypass && (accept || p != 0).
  - On each step, p <= (p == L−1) ? 0 : p+1. For L = 1, p stays at 0.
- Comb section (combinational, input rate):
  - c0 = sign-extended x_n; c_i = c_{i−1} − d_i.
  - On accept, d_i <= c_{i−1}.
- Zero-stuff register: on step, u <= accept ? c_N : 0.
  - v1 <= step, cleared when EN is low.
- Integrators, on v1: I_1 <= I_1 + u, and I_j <= I_j + I_{j−1} using pre-update values (pipelined).
  - All integrator arithmetic is ACC_WIDTH two's-complement with wrap-around, which is intended.
- Output, on v1:
  - Scale: s = (N_STAGES−1)*k_r. Compute r = (I_N + (s > 0 ? 2^(s−1) : 0)) >>> s, i.e. round half-up.
  - Saturate r to [−32768, 32767], then load y_n; out_valid <= 1.
  - On cycles without v1: out_valid = 0 and y_n holds.
- Latency:
  - First out_valid occurs 2 edges after the accepting edge.
  - Output sample j = impulse-response convolution delayed by 4 output ticks. For L = 1, y_j = x_{j−4}.
- Gain: DC gain L^(N−1) is removed exactly by s, giving unity DC gain.
- Bypass:
  - Filter state is cleared and p = 0.
  - On accept, y_n <= x_n and out_valid <= 1, with 1-cycle latency.
- EN low: all registers hold, in_ready = 0, out_valid = 0.
- Factor change: if the clamped Interpolation_Factor ≠ k_r at an edge:
  - k_r updates.
  - Filter state and p are flushed for that cycle, as in reset except y_n holds.
  - in_ready = 0 during that cycle.

Decomposition:
- Shared package cic_pkg:
  - DATA_WIDTH, ACC_WIDTH, N_STAGES, MAX_LOG2_L.
  - sat_round function, shared with the decimator output stage.
- One sub-module: cic_integrator_stage (single ACC_WIDTH accumulator with enable and sync clear), instantiated N_STAGES times.
- Combs stay inline.

Test Plan:
- Reset mid-stream: stream at k = 2, assert rst for 1 cycle → next cycle y_n = 0, out_valid = 0, in_ready = 1; the first 4 post-reset outputs are 0 for zero input.
- k = 0, in_valid always high, x = 0x1234, 0x0100, 0xF000, … → in_ready constantly 1; out_valid every cycle; y_j = x_{j−4}.
- k = 1, single impulse 0x7FFF followed by zeros → nonzero outputs in order 0x1000, 0x4000, 0x5FFF, 0x4000, 0x1000, then all 0.
- k = 2, DC input 0x4000 → in_ready pattern 1,0,0,0 repeating; after transient, y_n = 0x4000 on every out_valid.
- k = 4, DC input 0x7FFF → steady y_n = 0x7FFF with no wrap; in_valid dropped at p == 0 for 3 cycles → out_valid low for those 3 cycles, then the stream resumes unchanged.
- bypass = 1, x = 0x8001 → y_n = 0x8001 one cycle later with out_valid = 1; EN = 0 → in_ready = 0, out_valid = 0, y_n held.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared CIC constants and the output rounding/saturation stage used by both the
// interpolator and the decimator.
package cic_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int N_STAGES    = 4;
    localparam int MAX_LOG2_L  = 4;
    localparam int ACC_WIDTH   = DATA_WIDTH + N_STAGES * MAX_LOG2_L - MAX_LOG2_L;
    localparam int K_WIDTH     = 3;
    localparam int SHIFT_WIDTH = $clog2((N_STAGES - 1) * MAX_LOG2_L + 1);

    localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH + 1)'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH + 1)'(-(2 ** (DATA_WIDTH - 1)));

    // Round half-up by 2^shift, then clamp to the signed output range.
    // One guard bit keeps the rounding bias from overflowing the accumulator.
    function automatic logic [DATA_WIDTH-1:0] sat_round(
        input logic signed [ACC_WIDTH-1:0] acc,
        input logic [SHIFT_WIDTH-1:0]      shift
    );
        logic signed [ACC_WIDTH:0] half;
        logic signed [ACC_WIDTH:0] biased;
        logic signed [ACC_WIDTH:0] r;
        half = '0;
        if (shift != '0) begin
            half = (ACC_WIDTH + 1)'(1) << (shift - 1'b1);
        end
        biased = {acc[ACC_WIDTH-1], acc} + half;
        r = biased >>> shift;
        if (r > SAT_HI) begin
            return SAT_HI[DATA_WIDTH-1:0];
        end
        if (r < SAT_LO) begin
            return SAT_LO[DATA_WIDTH-1:0];
        end
        return r[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One wrap-around CIC integrator: accumulates din when enabled, clears synchronously.
module cic_integrator_stage
    import cic_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [ACC_WIDTH-1:0] din,
    output logic [ACC_WIDTH-1:0] acc
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/cic_interpolator.sv
// N-stage CIC interpolator: combs at input rate, zero-stuff by 2^k, integrators at
// output rate, then gain-normalising round/saturate to s16.15.
module cic_interpolator
    import cic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EN,
    input  logic                  bypass,
    input  logic [DATA_WIDTH-1:0] x_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [K_WIDTH-1:0]    Interpolation_Factor,
    output logic [DATA_WIDTH-1:0] y_n,
    output logic                  out_valid
);

    logic [K_WIDTH-1:0]     k_clamped;
    logic [K_WIDTH-1:0]     k_r_q, k_r_d;
    logic [MAX_LOG2_L-1:0]  p_q, p_d, p_last;
    logic [ACC_WIDTH-1:0]   u_q, u_d;
    logic                   v1_q, v1_d;
    logic [DATA_WIDTH-1:0]  y_q, y_d;
    logic                   out_valid_q, out_valid_d;
    logic [SHIFT_WIDTH-1:0] shift;

    logic [ACC_WIDTH-1:0] d_q      [N_STAGES];
    logic [ACC_WIDTH-1:0] d_d      [N_STAGES];
    logic [ACC_WIDTH-1:0] comb_c   [N_STAGES+1];
    logic [ACC_WIDTH-1:0] integ_in [N_STAGES];
    logic [ACC_WIDTH-1:0] integ_acc[N_STAGES];

    logic factor_change, flush, accept, step;

    assign k_clamped = (Interpolation_Factor > K_WIDTH'(MAX_LOG2_L)) ? K_WIDTH'(MAX_LOG2_L)
                                                                     : Interpolation_Factor;
    assign factor_change = EN && (k_clamped != k_r_q);
    // Bypass and factor changes both discard filter history so a later restart is clean.
    assign flush    = EN && (bypass || factor_change);
    assign in_ready = EN && !rst && !factor_change && (bypass || (p_q == '0));
    assign accept   = in_valid && in_ready;
    assign step     = EN && !bypass && !factor_change && (accept || (p_q != '0));
    assign p_last   = ~({MAX_LOG2_L{1'b1}} << k_r_q);
    assign shift    = SHIFT_WIDTH'(k_r_q) * SHIFT_WIDTH'(N_STAGES - 1);

    always_comb begin
        comb_c[0] = {{(ACC_WIDTH - DATA_WIDTH){x_n[DATA_WIDTH-1]}}, x_n};
        for (int i = 0; i < N_STAGES; i++) begin
            comb_c[i+1] = comb_c[i] - d_q[i];
        end
    end

    generate
        for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_stage
            assign d_d[gi] = flush ? '0 : (accept ? comb_c[gi] : d_q[gi]);

            if (gi == 0) begin : g_first
                assign integ_in[gi] = u_q;
            end else begin : g_chain
                // Each integrator sees its predecessor's pre-update value (pipelined chain).
                assign integ_in[gi] = integ_acc[gi-1];
            end

            cic_integrator_stage u_integ (
                .clk (clk),
                .rst (rst),
                .en  (EN && v1_q),
                .clr (flush),
                .din (integ_in[gi]),
                .acc (integ_acc[gi])
            );
        end
    endgenerate

    always_comb begin
        k_r_d       = EN ? k_clamped : k_r_q;
        p_d         = p_q;
        u_d         = u_q;
        v1_d        = step;
        y_d         = y_q;
        out_valid_d = 1'b0;

        if (flush) begin
            p_d = '0;
            u_d = '0;
        end else if (step) begin
            p_d = (p_q == p_last) ? '0 : p_q + 1'b1;
            u_d = accept ? comb_c[N_STAGES] : '0;
        end

        if (EN && bypass) begin
            if (accept) begin
                y_d         = x_n;
                out_valid_d = 1'b1;
            end
        end else if (EN && !factor_change && v1_q) begin
            y_d         = sat_round(integ_acc[N_STAGES-1], shift);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_r_q       <= k_clamped;
            p_q         <= '0;
            u_q         <= '0;
            v1_q        <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            k_r_q       <= k_r_d;
            p_q         <= p_d;
            u_q         <= u_d;
            v1_q        <= v1_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
        for (int i = 0; i < N_STAGES; i++) begin
            d_q[i] <= rst ? '0 : d_d[i];
        end
    end

    assign y_n       = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator against a convolution model of the CIC response.
module tb_cic_interpolator;

    logic        clk = 1'b0;
    logic        rst, EN, bypass, in_valid, in_ready, out_valid;
    logic [15:0] x_n, y_n;
    logic [2:0]  Interpolation_Factor;

    int n_checks = 0;
    int n_fail   = 0;

    int          xs[$];
    logic [15:0] obs[$];
    bit          rdy_h[$];
    bit          ov_h[$];

    cic_interpolator dut (
        .clk                  (clk),
        .rst                  (rst),
        .EN                   (EN),
        .bypass               (bypass),
        .x_n                  (x_n),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .Interpolation_Factor (Interpolation_Factor),
        .y_n                  (y_n),
        .out_valid            (out_valid)
    );

    always #5 clk = ~clk;

    task automatic clear_hist();
        xs.delete();
        obs.delete();
        rdy_h.delete();
        ov_h.delete();
    endtask

    task automatic apply_reset(input logic [2:0] k);
        rst = 1'b1; EN = 1'b1; bypass = 1'b0; in_valid = 1'b0; x_n = '0;
        Interpolation_Factor = k;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_hist();
    endtask

    // One clock of stimulus; records acceptance, readiness and any emitted sample.
    task automatic drive_cycle(input logic v, input logic [15:0] x);
        in_valid = v;
        x_n      = x;
        @(negedge clk);
        rdy_h.push_back(in_ready);
        if (v && in_ready) xs.push_back(int'($signed(x)));
        @(posedge clk);
        #1;
        ov_h.push_back(out_valid);
        if (out_valid) obs.push_back(y_n);
    endtask

    function automatic int clampk(input int k);
        return (k > 4) ? 4 : k;
    endfunction

    // Output tick j: zero-stuffed input convolved with the boxcar(L)^4 impulse response,
    // delayed 4 ticks, divided by L^3 with round half-up, saturated to 16 bits.
    function automatic logic [15:0] model_y(input int j, input int k);
        int      L, s, n_out, m;
        longint  h[$];
        longint  t[$];
        longint  acc, w, r;
        L = 1 << k;
        s = 3 * k;
        h.delete();
        h.push_back(1);
        repeat (4) begin
            t.delete();
            for (int n = 0; n < h.size() + L - 1; n++) begin
                acc = 0;
                for (int i = 0; i < L; i++) begin
                    if (n - i >= 0 && n - i < h.size()) acc += h[n-i];
                end
                t.push_back(acc);
            end
            h = t;
        end
        w = 0;
        n_out = j - 4;
        for (int i = 0; i < h.size(); i++) begin
            m = n_out - i;
            if (m >= 0 && m % L == 0 && m / L < xs.size()) w += h[i] * longint'(xs[m / L]);
        end
        r = (s == 0) ? w : ((w + (longint'(1) << (s - 1))) >>> s);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[15:0];
    endfunction

    task automatic test_reset();
        logic [15:0] exp_v;
        apply_reset(3'd2);
        for (int c = 0; c < 20; c++) drive_cycle(1'b1, 16'($urandom_range(0, 65535)));
        rst = 1'b1; in_valid = 1'b1; x_n = 16'h5555;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (y_n !== 16'h0000) begin n_fail++; $display("FAIL reset_y: got %h want 0000", y_n); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        clear_hist();
        for (int c = 0; c < 8; c++) drive_cycle(1'b1, 16'h0000);
        n_checks++;
        if (obs.size() < 4) begin n_fail++; $display("FAIL reset_out_count: got %0d want >=4", obs.size()); end
        for (int j = 0; j < 4 && j < obs.size(); j++) begin
            exp_v = 16'h0000;
            n_checks++;
            if (obs[j] !== exp_v) begin n_fail++; $display("FAIL reset_zero_out[%0d]: got %h want %h", j, obs[j], exp_v); end
        end
        $display("test_reset: %0d outputs after mid-stream reset", obs.size());
    endtask

    task automatic test_k0_passthrough();
        logic [15:0] seq[3];
        logic [15:0] exp_v;
        seq[0] = 16'h1234; seq[1] = 16'h0100; seq[2] = 16'hF000;
        apply_reset(3'd0);
        for (int c = 0; c < 24; c++) drive_cycle(1'b1, (c < 3) ? seq[c] : 16'($urandom_range(0, 65535)));
        for (int c = 0; c < 24; c++) begin
            n_checks++;
            if (rdy_h[c] !== 1'b1) begin n_fail++; $display("FAIL k0_in_ready[%0d]: got %b want 1", c, rdy_h[c]); end
        end
        n_checks++;
        if (obs.size() != 23) begin n_fail++; $display("FAIL k0_out_count: got %0d want 23", obs.size()); end
        for (int j = 0; j < obs.size(); j++) begin
            exp_v = (j >= 4) ? 16'(xs[j-4]) : 16'h0000;
            n_checks++;
            if (obs[j] !== exp_v) begin n_fail++; $display("FAIL k0_delay4[%0d]: got %h want %h", j, obs[j], exp_v); end
        end
        $display("test_k0_passthrough: %0d outputs", obs.size());
    endtask

    task automatic test_impulse_k1();
        logic [15:0] imp[5];
        logic [15:0] exp_v;
        imp[0] = 16'h1000; imp[1] = 16'h4000; imp[2] = 16'h5FFF; imp[3] = 16'h4000; imp[4] = 16'h1000;
        apply_reset(3'd1);
        for (int c = 0; c < 20; c++) drive_cycle(1'b1, (c == 0) ? 16'h7FFF : 16'h0000);
        n_checks++;
        if (obs.size() != 19) begin n_fail++; $display("FAIL k1_out_count: got %0d want 19", obs.size()); end
        for (int j = 0; j < obs.size(); j++) begin
            exp_v = (j >= 4 && j <= 8) ? imp[j-4] : 16'h0000;
            n_checks++;
            if (obs[j] !== exp_v) begin n_fail++; $display("FAIL k1_impulse[%0d]: got %h want %h", j, obs[j], exp_v); end
        end
        $display("test_impulse_k1: %0d outputs", obs.size());
    endtask

    task automatic test_dc_k2();
        logic [15:0] exp_v;
        apply_reset(3'd2);
        for (int c = 0; c < 48; c++) drive_cycle(1'b1, 16'h4000);
        for (int c = 0; c < 48; c++) begin
            n_checks++;
            if (rdy_h[c] !== (c % 4 == 0)) begin n_fail++; $display("FAIL k2_ready_pattern[%0d]: got %b want %b", c, rdy_h[c], (c % 4 == 0)); end
        end
        n_checks++;
        if (obs.size() != 47) begin n_fail++; $display("FAIL k2_out_count: got %0d want 47", obs.size()); end
        for (int j = 0; j < obs.size(); j++) begin
            exp_v = model_y(j, 2);
            n_checks++;
            if (obs[j] !== exp_v) begin n_fail++; $display("FAIL k2_dc_model[%0d]: got %h want %h", j, obs[j], exp_v); end
            if (j >= 20) begin
                n_checks++;
                if (obs[j] !== 16'h4000) begin n_fail++; $display("FAIL k2_dc_steady[%0d]: got %h want 4000", j, obs[j]); end
            end
        end
        $display("test_dc_k2: %0d outputs", obs.size());
    endtask

    task automatic test_stall_k4();
        logic [15:0] exp_v;
        apply_reset(3'd4);
        for (int c = 0; c < 160; c++) drive_cycle(1'b1, 16'h7FFF);
        for (int c = 0; c < 3; c++)   drive_cycle(1'b0, 16'h7FFF);
        for (int c = 0; c < 48; c++)  drive_cycle(1'b1, 16'h7FFF);
        n_checks++;
        if (ov_h[160] !== 1'b1) begin n_fail++; $display("FAIL k4_ov_before_stall: got %b want 1", ov_h[160]); end
        for (int c = 161; c <= 163; c++) begin
            n_checks++;
            if (ov_h[c] !== 1'b0) begin n_fail++; $display("FAIL k4_ov_stall[%0d]: got %b want 0", c, ov_h[c]); end
        end
        n_checks++;
        if (ov_h[164] !== 1'b1) begin n_fail++; $display("FAIL k4_ov_resume: got %b want 1", ov_h[164]); end
        n_checks++;
        if (obs.size() != 207) begin n_fail++; $display("FAIL k4_out_count: got %0d want 207", obs.size()); end
        for (int j = 0; j < obs.size(); j++) begin
            exp_v = model_y(j, 4);
            n_checks++;
            if (obs[j] !== exp_v) begin n_fail++; $display("FAIL k4_dc_model[%0d]: got %h want %h", j, obs[j], exp_v); end
            if (j >= 70) begin
                n_checks++;
                if (obs[j] !== 16'h7FFF) begin n_fail++; $display("FAIL k4_dc_steady[%0d]: got %h want 7fff", j, obs[j]); end
            end
        end
        $display("test_stall_k4: %0d outputs", obs.size());
    endtask

    task automatic test_factor_change();
        int          ka, kb;
        logic [15:0] exp_v;
        ka = $urandom_range(5, 7);
        kb = $urandom_range(0, 3);
        apply_reset(3'(ka));
        for (int c = 0; c < 120; c++) drive_cycle($urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)));
        for (int j = 0; j < obs.size(); j++) begin
            exp_v = model_y(j, clampk(ka));
            n_checks++;
            if (obs[j] !== exp_v) begin n_fail++; $display("FAIL rand_ka%0d[%0d]: got %h want %h", ka, j, obs[j], exp_v); end
        end
        $display("test_factor_change: k=%0d, %0d samples, %0d outputs", ka, xs.size(), obs.size());
        clear_hist();
        Interpolation_Factor = 3'(kb);
        for (int c = 0; c < 120; c++) drive_cycle($urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)));
        n_checks++;
        if (rdy_h[0] !== 1'b0) begin n_fail++; $display("FAIL change_in_ready: got %b want 0", rdy_h[0]); end
        n_checks++;
        if (ov_h[0] !== 1'b0) begin n_fail++; $display("FAIL change_out_valid: got %b want 0", ov_h[0]); end
        for (int j = 0; j < obs.size(); j++) begin
            exp_v = model_y(j, kb);
            n_checks++;
            if (obs[j] !== exp_v) begin n_fail++; $display("FAIL rand_kb%0d[%0d]: got %h want %h", kb, j, obs[j], exp_v); end
        end
        $display("test_factor_change: k=%0d, %0d samples, %0d outputs", kb, xs.size(), obs.size());
    endtask

    task automatic test_bypass_en();
        apply_reset(3'd2);
        bypass = 1'b1;
        drive_cycle(1'b1, 16'h8001);
        n_checks++;
        if (rdy_h[0] !== 1'b1) begin n_fail++; $display("FAIL bypass_in_ready: got %b want 1", rdy_h[0]); end
        n_checks++;
        if (y_n !== 16'h8001) begin n_fail++; $display("FAIL bypass_y: got %h want 8001", y_n); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_out_valid: got %b want 1", out_valid); end
        drive_cycle(1'b0, 16'h2222);
        n_checks++;
        if (out_valid !== 1'b0 || y_n !== 16'h8001) begin
            n_fail++; $display("FAIL bypass_idle: got ov=%b y=%h want ov=0 y=8001", out_valid, y_n);
        end
        EN = 1'b0;
        drive_cycle(1'b1, 16'h1234);
        n_checks++;
        if (rdy_h[2] !== 1'b0) begin n_fail++; $display("FAIL en_low_in_ready: got %b want 0", rdy_h[2]); end
        n_checks++;
        if (out_valid !== 1'b0 || y_n !== 16'h8001) begin
            n_fail++; $display("FAIL en_low_hold: got ov=%b y=%h want ov=0 y=8001", out_valid, y_n);
        end
        bypass = 1'b0;
        drive_cycle(1'b1, 16'h4321);
        n_checks++;
        if (rdy_h[3] !== 1'b0 || out_valid !== 1'b0 || y_n !== 16'h8001) begin
            n_fail++; $display("FAIL en_low_filter_hold: got rdy=%b ov=%b y=%h want rdy=0 ov=0 y=8001", rdy_h[3], out_valid, y_n);
        end
        EN = 1'b1;
        $display("test_bypass_en: bypass and enable-hold sequence done");
    endtask

    initial begin
        test_reset();
        test_k0_passthrough();
        test_impulse_k1();
        test_dc_k2();
        test_stall_k4();
        test_factor_change();
        test_bypass_en();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
